duft_ap_chain_master: RTL

DUFT_AP_CHAIN_MASTER -- requirements
Module: duft_ap_chain_master

---
 rtl/duft_ap_chain_master.sv | 138 +++++++++++++
 1 files changed

// File: rtl/duft_ap_chain_master.sv
// duft_ap_chain_master
//   Single-outstanding command master for an HLS-style ap_ctrl_chain block.
//   A host command (read/write) is latched, the DUFT is waited on until idle,
//   started with ap_start, and its ap_done is held off via ap_continue until
//   the host takes the response. Any wait state that lasts TIMEOUT cycles
//   aborts the transaction with an error response.
//
// Ports
//   clk, ap_rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_*          host command channel
//   rsp_valid/rsp_ready/rsp_rdata/err  host response channel
//   addr, wr_data, rd_wr               operands presented to the DUFT
//   ap_start, ap_continue              DUFT block-level control out
//   ap_idle, ap_ready, ap_done         DUFT block-level status in
//   ap_return                          DUFT result
//   err_count                          saturating count of timeouts
module duft_ap_chain_master #(
  parameter int          TIMEOUT      = 200,
  parameter logic [31:0] INVALID_ADDR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        ap_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic        rd_wr,
  output logic        ap_start,
  output logic        ap_continue,
  input  logic        ap_idle,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic [31:0] ap_return,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_START, S_WAIT_DONE, S_RESP
  } state_t;

  // Counter only needs to reach TIMEOUT-1: the cycle it sits there is the
  // last one allowed, so it never has to hold TIMEOUT itself.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_rd_wr;
  logic [31:0]   lat_addr, lat_wdata;
  logic          in_wait, expired, finish, abort;

  assign in_wait = (state == S_WAIT_IDLE) || (state == S_START) ||
                   (state == S_WAIT_DONE);
  assign expired = in_wait && (cnt == CNT_LAST);

  // Next state. ap_ready/ap_done are only looked at in START/WAIT_DONE, so
  // stray pulses while idle or waiting for idle are ignored. A completion
  // seen in the same cycle as the timeout wins.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:      if (cmd_valid) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (ap_idle)      state_nxt = S_START;
        else if (expired) abort     = 1'b1;
      end
      S_START: begin
        if (ap_ready) begin
          if (ap_done) finish    = 1'b1;
          else         state_nxt = S_WAIT_DONE;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (ap_done)      finish = 1'b1;
        else if (expired) abort  = 1'b1;
      end
      S_RESP:      if (rsp_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (finish || abort) state_nxt = S_RESP;
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ap_start  <= 1'b0;
      lat_rd_wr <= 1'b1;
      lat_addr  <= INVALID_ADDR;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      // Every wait state is entered from a different state, so a state
      // change is exactly an entry and restarts the count.
      if (state_nxt != state) cnt <= '0;
      else if (in_wait)       cnt <= cnt + 1'b1;
      // ap_start is high for exactly the cycles spent in START.
      ap_start <= (state_nxt == S_START);
      if (state == S_IDLE && cmd_valid) begin
        lat_rd_wr <= cmd_rd_wr;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
      if (finish) begin
        rsp_rdata <= lat_rd_wr ? ap_return : 32'h0;
        rsp_err   <= 1'b0;
      end else if (abort) begin
        rsp_rdata <= 32'hFFFF_FFFF;
        rsp_err   <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  // Done stays held in the DUFT until the host consumes a good response;
  // aborted transactions never release it.
  assign ap_continue = (state == S_RESP) && rsp_ready && !rsp_err;
  assign addr        = in_wait ? lat_addr  : INVALID_ADDR;
  assign rd_wr       = in_wait ? lat_rd_wr : 1'b1;
  assign wr_data     = lat_wdata;

endmodule
